adder_arb: RTL and testbench

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb_pkg.sv | 21 ++
 rtl/adder_arb_add.sv | 15 +
 rtl/adder_arb.sv | 133 +++++++++++++
 tb/tb_adder_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg -- shared constants and types for the adder_arb slice.
//   DATA_W   : operand/result width
//   NREQ_DEF : default number of requesters
//   slot_state_e : state of the single-entry result slot (EMPTY/FULL)
//   add_ovf  : signed-overflow rule for a two's-complement add
package adder_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int NREQ_DEF = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Overflow happens only when both operands share a sign and the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_arb_add.sv
// adder_arb_add -- plain 32-bit adder, carry-out discarded (sum mod 2^32).
//   a_i   : operand A
//   b_i   : operand B
//   sum_o : a_i + b_i, truncated to DATA_W bits
module adder_arb_add
  import adder_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arb.sv
// adder_arb -- NREQ requesters share one 32-bit adder through a round-robin
// arbiter; the sum lands in a single registered result slot.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   req_valid    : per-requester operand valid
//   req_a, req_b : packed operands, requester i at bits [32i+31:32i]
//   req_ready    : one-hot grant (combinational)
//   rsp_valid    : result slot is FULL
//   rsp_ready    : consumer takes the result this cycle
//   rsp_id       : requester that owns rsp_result
//   rsp_result   : registered sum
//   rsp_ovf      : registered signed-overflow flag (only with ADDER_ARB_OVF_EN)
// Build option: define ADDER_ARB_OVF_EN to add the rsp_ovf port and logic.
//
// Handshake: a beat moves when valid && ready on the same rising edge. valid
// never depends on ready; req_ready may depend on req_valid and rsp_ready, and
// asserts only for a requester whose req_valid is high.
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_result
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);

  slot_state_e       state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
`ifdef ADDER_ARB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [IDW-1:0]    grant_idx;
  logic              any_valid;
  logic              slot_free;
  logic              xfer;
  logic [DATA_W-1:0] op_a, op_b, sum;

  // Round-robin search. Walking the offsets from highest to lowest lets the
  // lowest offset from rr_ptr_q win without an early exit.
  always_comb begin
    int p;
    p         = 0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      p = int'(rr_ptr_q) + off;
      if (p >= NREQ) p = p - NREQ;
      if (req_valid[p]) begin
        grant_idx = IDW'(p);
        any_valid = 1'b1;
      end
    end
  end

  // rst_n gates the grant so nothing is accepted while reset is held.
  assign slot_free = rst_n && ((state_q == EMPTY) || rsp_ready);
  assign xfer      = slot_free && any_valid;
  assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

  // Operand mux in front of the single shared adder.
  assign op_a = req_a[grant_idx*DATA_W +: DATA_W];
  assign op_b = req_b[grant_idx*DATA_W +: DATA_W];

  adder_arb_add u_add (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (sum)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    result_d = result_q;
`ifdef ADDER_ARB_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (xfer) begin
      state_d  = FULL;
      id_d     = grant_idx;
      result_d = sum;
`ifdef ADDER_ARB_OVF_EN
      ovf_d    = add_ovf(op_a[DATA_W-1], op_b[DATA_W-1], sum[DATA_W-1]);
`endif
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      id_q     <= '0;
      result_q <= '0;
`ifdef ADDER_ARB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
`ifdef ADDER_ARB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
`ifdef ADDER_ARB_OVF_EN
  assign rsp_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// tb_adder_arb -- directed bench for adder_arb (NREQ = 4).
// Inputs change on the falling edge; combinational req_ready is sampled 1ns
// later, registered rsp_* outputs 1ns after the rising edge.
module tb_adder_arb;

  localparam int NREQ = 4;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]  req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [31:0]      rsp_result;
`ifdef ADDER_ARB_OVF_EN
  logic             rsp_ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sum_tab [4] = '{32'd11, 32'd22, 32'd33, 32'd44};

  adder_arb #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One transfer from a single requester, checked at grant and at result.
  task automatic xfer_one(input string tag, input int idx,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum);
    logic [NREQ-1:0] oh;
    @(negedge clk);
    oh = '0;
    oh[idx] = 1'b1;
    req_valid = oh;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    rsp_ready = 1'b1;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(oh));
    exp_q.push_back(exp_sum);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    check({tag, "_result"}, rsp_result, exp_q.pop_front());
  endtask

  initial begin
    logic [NREQ-1:0] e;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // reset state, with requests present
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
`ifdef ADDER_ARB_OVF_EN
    check("rst_ovf", 32'(rsp_ovf), 32'd0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;

    // first transfer: 5 + 7
    xfer_one("basic", 0, 32'd5, 32'd7, 32'd12);
    // wrap-around; also moves rr_ptr back to 0
    xfer_one("wrap", 3, 32'hFFFF_FFFF, 32'd1, 32'd0);

    // all requesting: grants 0,1,2,3,0,1,2,3, result one cycle later
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = 32'(10 * (i + 1));
      req_b[i*32 +: 32] = 32'(i + 1);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = '0;
      e[k % 4] = 1'b1;
      check("rr_ready", 32'(req_ready), 32'(e));
      exp_q.push_back(sum_tab[k % 4]);
      @(posedge clk);
      #1;
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_result", rsp_result, exp_q.pop_front());
      @(negedge clk);
    end

    // back-pressure: slot FULL (id 3, 44), nothing granted, outputs stable
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_id", 32'(rsp_id), 32'd3);
      check("hold_result", rsp_result, 32'd44);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("release_ready", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    check("release_id", 32'(rsp_id), 32'd1);
    check("release_result", rsp_result, 32'd22);

    // reset mid-operation: FULL with rr_ptr = 2
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_result", rsp_result, 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1 check("postrst_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("postrst_id", 32'(rsp_id), 32'd0);
    check("postrst_result", rsp_result, 32'd11);

    // operand sign combinations
    xfer_one("pos_neg", 2, 32'd5, 32'hFFFF_FFFD, 32'd2);
`ifdef ADDER_ARB_OVF_EN
    check("pos_neg_ovf", 32'(rsp_ovf), 32'd0);
`endif
    xfer_one("neg_neg", 2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`ifdef ADDER_ARB_OVF_EN
    check("neg_neg_ovf", 32'(rsp_ovf), 32'd0);
`endif
    xfer_one("neg_pos", 2, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    xfer_one("pos_ovf", 2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
`ifdef ADDER_ARB_OVF_EN
    check("pos_ovf_flag", 32'(rsp_ovf), 32'd1);
`endif
    xfer_one("neg_ovf", 2, 32'h8000_0000, 32'h8000_0000, 32'd0);
`ifdef ADDER_ARB_OVF_EN
    check("neg_ovf_flag", 32'(rsp_ovf), 32'd1);
`endif

    // no requests: nothing granted, slot drains to EMPTY
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    #1 check("idle_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("idle_valid", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
